// File: rtl/vga_tile_paint_controller.sv
// vga_tile_paint_controller: PS/2 command sequencer with blank-synchronised 8x8 tile memory and cursor-overlaid pixel output
module vga_tile_paint_controller #(
  parameter int IMG_X0 = 242,
  parameter int IMG_Y0 = 142,
  parameter int BORDER = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iScanCode,
  input  logic       iScanValid,
  input  logic [9:0] iHcounter,
  input  logic [9:0] iVcounter,
  output logic [7:0] oXRedCounter,
  output logic [7:0] oYRedCounter,
  output logic [2:0] oColorCuadro,
  output logic [2:0] oVGA_RGB,
  output logic       oBusy,
  output logic       oOverflow
);
  typedef enum logic [1:0] {IDLE, PAINT_WAIT, PAINT_WR, CLEAR} state_t;
  localparam logic [9:0] X0 = 10'(IMG_X0);
  localparam logic [9:0] X1 = 10'(IMG_X0 + 256);
  localparam logic [9:0] Y0 = 10'(IMG_Y0);
  localparam logic [9:0] Y1 = 10'(IMG_Y0 + 256);
  localparam logic [4:0] B_LO = 5'(BORDER);
  localparam logic [4:0] B_HI = 5'(32 - BORDER);
  state_t state, state_n;
  logic [2:0] tile [64];
  logic brk, act, blank, go_paint, go_clear, wr, in_img, in_cur, on_edge;
  logic [5:0] p_idx, cnt, wr_idx;
  logic [2:0] p_col, wr_col, rd_col;
  logic [7:0] lx, ly;
  assign act = iScanValid && !brk && iScanCode != 8'hF0;
  assign go_paint = act && iScanCode == 8'h5A;
  assign go_clear = act && iScanCode == 8'h21;
  assign blank = iVcounter < Y0 || iVcounter >= Y1;
  assign oBusy = state != IDLE;
  assign lx = 8'(iHcounter - X0);
  assign ly = 8'(iVcounter - Y0);
  assign in_img = iHcounter >= X0 && iHcounter < X1 && !blank;
  assign rd_col = tile[{ly[7:5], lx[7:5]}];
  assign in_cur = lx[7:5] == oXRedCounter[7:5] && ly[7:5] == oYRedCounter[7:5];
  assign on_edge = lx[4:0] < B_LO || lx[4:0] >= B_HI || ly[4:0] < B_LO || ly[4:0] >= B_HI;
  always_comb begin
    state_n = state;
    wr = 1'b0;
    wr_idx = p_idx;
    wr_col = p_col;
    case (state)
      IDLE:       state_n = go_paint ? PAINT_WAIT : go_clear ? CLEAR : IDLE;
      PAINT_WAIT: state_n = blank ? PAINT_WR : PAINT_WAIT;
      PAINT_WR: begin
        wr = 1'b1;
        state_n = IDLE;
      end
      default: begin
        wr = blank;
        wr_idx = cnt;
        wr_col = 3'd0;
        state_n = blank && cnt == 6'd63 ? IDLE : CLEAR;
      end
    endcase
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      brk <= 1'b0;
      oXRedCounter <= 8'd0;
      oYRedCounter <= 8'd0;
      oColorCuadro <= 3'b001;
      oVGA_RGB <= 3'd0;
      oOverflow <= 1'b0;
      p_idx <= 6'd0;
      p_col <= 3'd0;
      cnt <= 6'd0;
      for (int i = 0; i < 64; i++) tile[i] <= 3'd0;
    end else begin
      state <= state_n;
      brk <= iScanValid ? !brk && iScanCode == 8'hF0 : brk;
      oYRedCounter <= !act ? oYRedCounter : iScanCode == 8'h1D ? oYRedCounter - 8'd32 :
                      iScanCode == 8'h1B ? oYRedCounter + 8'd32 : oYRedCounter;
      oXRedCounter <= !act ? oXRedCounter : iScanCode == 8'h1C ? oXRedCounter - 8'd32 :
                      iScanCode == 8'h23 ? oXRedCounter + 8'd32 : oXRedCounter;
      oColorCuadro <= act && iScanCode == 8'h29 ? oColorCuadro + 3'd1 : oColorCuadro;
      oOverflow <= oOverflow | (oBusy && (go_paint || go_clear));
      if (state == IDLE && go_paint) begin
        p_idx <= {oYRedCounter[7:5], oXRedCounter[7:5]};
        p_col <= oColorCuadro;
      end
      cnt <= state == IDLE ? 6'd0 : state == CLEAR && blank ? cnt + 6'd1 : cnt;
      if (wr) tile[wr_idx] <= wr_col;
      oVGA_RGB <= !in_img ? 3'd0 : in_cur && on_edge ? ~rd_col : rd_col;
    end
  end
endmodule

// File: tb/tb_vga_tile_paint_controller.sv
// tb_vga_tile_paint_controller: vector table, corner sequences and randomized run against a behavioural model
module tb_vga_tile_paint_controller;
  logic Clock = 1'b0, Reset = 1'b0, iScanValid = 1'b0;
  logic [7:0] iScanCode = 8'd0;
  logic [9:0] iHcounter = 10'd0, iVcounter = 10'd0;
  logic [7:0] oXRedCounter, oYRedCounter;
  logic [2:0] oColorCuadro, oVGA_RGB;
  logic oBusy, oOverflow;
  int passed = 0, total = 0;
  int mx, my, mc, mclr, pidx, pcol, mrgb;
  bit mbrk, movf, mwait, mwr;
  int mt [64];
  logic [7:0] codes [10] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h5A, 8'h21, 8'hF0, 8'hE0, 8'h55};
  typedef struct {bit v; logic [7:0] c; int ex; int ey; int ec;} vec_t;
  vec_t tbl [$];
  vga_tile_paint_controller dut (
    .Clock(Clock), .Reset(Reset), .iScanCode(iScanCode), .iScanValid(iScanValid),
    .iHcounter(iHcounter), .iVcounter(iVcounter), .oXRedCounter(oXRedCounter),
    .oYRedCounter(oYRedCounter), .oColorCuadro(oColorCuadro), .oVGA_RGB(oVGA_RGB),
    .oBusy(oBusy), .oOverflow(oOverflow)
  );
  always #5 Clock = ~Clock;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  function automatic int pix(input int h, input int v);
    int lx, ly, c;
    if (h < 242 || h >= 498 || v < 142 || v >= 398) return 0;
    lx = h - 242;
    ly = v - 142;
    c = mt[(ly / 32) * 8 + lx / 32];
    if (lx / 32 == mx / 32 && ly / 32 == my / 32 &&
        (lx % 32 < 2 || lx % 32 >= 30 || ly % 32 < 2 || ly % 32 >= 30)) c = 7 - c;
    return c;
  endfunction
  function automatic bit mbusy();
    return mwait || mwr || mclr > 0;
  endfunction
  task automatic mreset();
    mx = 0; my = 0; mc = 1; mclr = 0; pidx = 0; pcol = 0; mrgb = 0;
    mbrk = 0; movf = 0; mwait = 0; mwr = 0;
    for (int i = 0; i < 64; i++) mt[i] = 0;
  endtask
  task automatic model(input bit v, input logic [7:0] c, input int h, input int vv);
    bit b, blank;
    b = mbusy();
    blank = vv < 142 || vv >= 398;
    mrgb = pix(h, vv);
    if (mwr) begin
      mt[pidx] = pcol;
      mwr = 0;
    end else if (mwait && blank) begin
      mwait = 0;
      mwr = 1;
    end else if (mclr > 0 && blank) begin
      mt[64 - mclr] = 0;
      mclr--;
    end
    if (v) begin
      if (mbrk) mbrk = 0;
      else if (c == 8'hF0) mbrk = 1;
      else case (c)
        8'h1D: my = (my + 224) % 256;
        8'h1B: my = (my + 32) % 256;
        8'h1C: mx = (mx + 224) % 256;
        8'h23: mx = (mx + 32) % 256;
        8'h29: mc = (mc + 1) % 8;
        8'h5A: if (b) movf = 1; else begin mwait = 1; pidx = (my / 32) * 8 + mx / 32; pcol = mc; end
        8'h21: if (b) movf = 1; else mclr = 64;
        default: ;
      endcase
    end
  endtask
  task automatic cyc(input bit v, input logic [7:0] c, input int h, input int vv);
    iScanValid = v;
    iScanCode = c;
    iHcounter = 10'(h);
    iVcounter = 10'(vv);
    @(posedge Clock);
    if (Reset) mreset();
    else model(v, c, h, vv);
    @(negedge Clock);
  endtask
  task automatic do_reset();
    Reset = 1'b1;
    cyc(0, 8'h00, 0, 0);
    Reset = 1'b0;
  endtask
  task automatic rd(input int idx, input int exp);
    cyc(0, 8'h00, 242 + (idx % 8) * 32 + 16, 142 + (idx / 8) * 32 + 16);
    chk($sformatf("tile%0d", idx), oVGA_RGB, exp);
  endtask
  task automatic check_all();
    chk("x", oXRedCounter, mx);
    chk("y", oYRedCounter, my);
    chk("colour", oColorCuadro, mc);
    chk("busy", oBusy, mbusy());
    chk("overflow", oOverflow, movf);
    chk("rgb", oVGA_RGB, mrgb);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n, vv;
    do_reset();
    repeat (10) cyc(0, 8'h00, 300, 300);
    chk("rst_x", oXRedCounter, 0);
    chk("rst_y", oYRedCounter, 0);
    chk("rst_colour", oColorCuadro, 1);
    chk("rst_busy", oBusy, 0);
    chk("rst_overflow", oOverflow, 0);
    chk("rst_rgb", oVGA_RGB, 0);
    tbl.push_back('{1, 8'h1D, 0, 224, 1});
    tbl.push_back('{1, 8'hF0, 0, 224, 1});
    tbl.push_back('{1, 8'h1D, 0, 224, 1});
    tbl.push_back('{1, 8'h1B, 0, 0, 1});
    tbl.push_back('{1, 8'h1C, 224, 0, 1});
    tbl.push_back('{1, 8'h23, 0, 0, 1});
    tbl.push_back('{1, 8'h23, 32, 0, 1});
    tbl.push_back('{0, 8'h1D, 32, 0, 1});
    tbl.push_back('{1, 8'h29, 32, 0, 2});
    tbl.push_back('{1, 8'hE0, 32, 0, 2});
    tbl.push_back('{1, 8'h55, 32, 0, 2});
    tbl.push_back('{1, 8'hF0, 32, 0, 2});
    tbl.push_back('{1, 8'hF0, 32, 0, 2});
    tbl.push_back('{1, 8'h29, 32, 0, 3});
    tbl.push_back('{1, 8'h29, 32, 0, 4});
    tbl.push_back('{1, 8'h29, 32, 0, 5});
    tbl.push_back('{1, 8'h29, 32, 0, 6});
    tbl.push_back('{1, 8'h29, 32, 0, 7});
    tbl.push_back('{1, 8'h29, 32, 0, 0});
    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].c, 100, 100);
      chk($sformatf("vec%0d_x", i), oXRedCounter, tbl[i].ex);
      chk($sformatf("vec%0d_y", i), oYRedCounter, tbl[i].ey);
      chk($sformatf("vec%0d_colour", i), oColorCuadro, tbl[i].ec);
    end
    do_reset();
    cyc(1, 8'h23, 0, 200);
    cyc(1, 8'h23, 0, 200);
    cyc(1, 8'h29, 0, 200);
    cyc(1, 8'h29, 0, 200);
    cyc(1, 8'h5A, 0, 200);
    chk("paint_busy_start", oBusy, 1);
    n = 0;
    for (int v = 201; v < 398; v++) begin
      cyc(0, 8'h00, 0, v);
      if (!oBusy) n++;
    end
    chk("paint_busy_hold", n, 0);
    cyc(0, 8'h00, 0, 398);
    chk("paint_busy_wr", oBusy, 1);
    cyc(0, 8'h00, 0, 399);
    chk("paint_busy_end", oBusy, 0);
    cyc(0, 8'h00, 322, 158);
    chk("paint_pixel", oVGA_RGB, 3);
    cyc(1, 8'h29, 0, 200);
    cyc(1, 8'h5A, 0, 200);
    cyc(1, 8'h23, 0, 200);
    cyc(1, 8'h5A, 0, 201);
    chk("ovf_set", oOverflow, 1);
    cyc(0, 8'h00, 0, 400);
    cyc(0, 8'h00, 0, 401);
    chk("ovf_busy_end", oBusy, 0);
    chk("ovf_sticky", oOverflow, 1);
    rd(2, 4);
    rd(3, 0);
    cyc(1, 8'h5A, 0, 200);
    cyc(0, 8'h00, 0, 400);
    cyc(1, 8'h5A, 0, 401);
    chk("enter_on_return_dropped", oBusy, 0);
    rd(3, 4);
    cyc(1, 8'h21, 0, 390);
    n = 0;
    vv = 391;
    while (oBusy && n < 300) begin
      cyc(0, 8'h00, 0, vv);
      vv = (vv + 1) % 525;
      n++;
    end
    chk("clear_cycles", n, 71);
    for (int i = 0; i < 64; i++) rd(i, 0);
    do_reset();
    cyc(1, 8'h23, 100, 100);
    cyc(1, 8'h1B, 100, 100);
    cyc(0, 8'h00, 274, 182);
    chk("cursor_edge_lo", oVGA_RGB, 7);
    cyc(0, 8'h00, 282, 182);
    chk("cursor_inner", oVGA_RGB, 0);
    cyc(0, 8'h00, 100, 182);
    chk("outside_image", oVGA_RGB, 0);
    cyc(0, 8'h00, 303, 182);
    chk("cursor_lx61", oVGA_RGB, 0);
    cyc(0, 8'h00, 304, 182);
    chk("cursor_lx62", oVGA_RGB, 7);
    cyc(1, 8'h5A, 0, 200);
    cyc(0, 8'h00, 0, 400);
    cyc(0, 8'h00, 0, 401);
    rd(9, 1);
    cyc(1, 8'h21, 0, 200);
    cyc(0, 8'h00, 0, 201);
    do_reset();
    chk("reset_abort_busy", oBusy, 0);
    chk("reset_abort_x", oXRedCounter, 0);
    rd(9, 0);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) do_reset();
      else cyc($urandom_range(2) == 0, codes[$urandom_range(9)], $urandom_range(540, 200), $urandom_range(524));
      check_all();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
